// File: rtl/generic_output_pkg.sv
// Shared constants for the generic_io blocks (generic_output, generic_input):
// FSM state encodings and a small sizing helper.
package generic_output_pkg;

  localparam logic [1:0] GIO_IDLE = 2'd0;
  localparam logic [1:0] GIO_ON   = 2'd1;
  localparam logic [1:0] GIO_OFF  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = GIO_IDLE,
    ST_ON   = GIO_ON,
    ST_OFF  = GIO_OFF
  } gio_state_e;

  function automatic int gio_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/generic_output_if.sv
// Pin-side signal bundle of generic_output: burst/hold requests in, pin drive and busy out.
interface generic_output_if;
  logic named_input;
  logic hold;
  logic named_output;
  logic busy;

  modport master (output named_input, output hold, input named_output, input busy);
  modport slave  (input named_input, input hold, output named_output, output busy);
endinterface

// File: rtl/generic_output_cycle_timer.sv
// Down-counting phase timer: load sets the count, it decrements to 0 and stops there.
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/generic_output.sv
// Burst pulse generator: each request yields PULSES on/off pulses on the pin,
// with a one-deep pending request; in idle the pin follows hold.
module generic_output
  import generic_output_pkg::*;
#(
  parameter int ON_CYCLES  = 5,
  parameter int OFF_CYCLES = 5,
  parameter int PULSES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  generic_output_if.slave  io
);

  localparam int PH_W = $clog2(gio_max(ON_CYCLES, OFF_CYCLES) + 1);
  localparam int PC_W = $clog2(PULSES + 1);
  localparam logic [PH_W-1:0] ON_LOAD  = PH_W'(ON_CYCLES - 1);
  localparam logic [PH_W-1:0] OFF_LOAD = PH_W'(OFF_CYCLES - 1);

  gio_state_e      r_state;
  gio_state_e      w_next_state;
  logic [PC_W-1:0] r_pulse_cnt;
  logic            r_pending;
  logic            r_named_output;
  logic            r_busy;

  logic            w_timer_load;
  logic [PH_W-1:0] w_timer_value;
  logic            w_timer_done;
  logic            w_last_pulse;
  logic            w_off_end;
  logic            w_burst_end;
  logic            w_start;
  logic            w_restart;
  logic            w_out_nxt;
  logic            w_busy_nxt;

  cycle_timer #(.W(PH_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_timer_load),
    .value (w_timer_value),
    .done  (w_timer_done)
  );

  assign w_last_pulse = (int'(r_pulse_cnt) + 1 >= PULSES);
  assign w_off_end    = (r_state == ST_OFF) && w_timer_done;
  assign w_burst_end  = w_off_end && w_last_pulse;
  assign w_start      = (r_state == ST_IDLE) && io.named_input;
  // A request landing on the final OFF edge chains straight into the next burst.
  assign w_restart    = w_burst_end && (r_pending || io.named_input);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (io.named_input) w_next_state = ST_ON;
      ST_ON:   if (w_timer_done) w_next_state = ST_OFF;
      ST_OFF: begin
        if (w_timer_done) begin
          if (!w_last_pulse || w_restart) begin
            w_next_state = ST_ON;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_timer_load  = (w_next_state != r_state) && (w_next_state != ST_IDLE);
    w_timer_value = (w_next_state == ST_ON) ? ON_LOAD : OFF_LOAD;
    w_busy_nxt    = (w_next_state != ST_IDLE);
    w_out_nxt     = io.hold;
    if (w_next_state == ST_ON) begin
      w_out_nxt = 1'b1;
    end else if (w_next_state == ST_OFF) begin
      w_out_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_named_output <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_named_output <= w_out_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  // Pending is consumed (or a concurrent extra request dropped) at every burst end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (w_burst_end) begin
      r_pending <= 1'b0;
    end else if ((r_state != ST_IDLE) && io.named_input) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse_cnt <= '0;
    end else if (w_start || w_restart) begin
      r_pulse_cnt <= '0;
    end else if (w_off_end) begin
      r_pulse_cnt <= r_pulse_cnt + PC_W'(1);
    end
  end

  assign io.named_output = r_named_output;
  assign io.busy         = r_busy;

endmodule

// File: tb/tb_generic_output.sv
// Bench for generic_output: burst-position reference model checked every cycle,
// plus directed bursts with literal busy-length and pin-pattern expectations.
module tb_generic_output;

  localparam int ON  = 5;
  localparam int OFF = 5;
  localparam int NP  = 2;
  localparam int P   = ON + OFF;
  localparam int LEN = NP * P;
  localparam logic [19:0] PAT = 20'b11111_00000_11111_00000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  generic_output_if io();

  generic_output #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PULSES(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a burst is just a position 0..LEN-1; the pin is high in the first ON of every P.
  typedef struct packed {
    logic        busy;
    logic        pend;
    logic        idle_out;
    logic [15:0] pos;
  } mstate_t;

  function automatic mstate_t step(input mstate_t s, input logic req, input logic hold);
    mstate_t n = s;
    if (!s.busy) begin
      if (req) begin
        n.busy = 1'b1;
        n.pos  = '0;
      end else begin
        n.idle_out = hold;
      end
    end else if (int'(s.pos) + 1 == LEN) begin
      if (s.pend || req) begin
        n.pos  = '0;
        n.pend = 1'b0;
      end else begin
        n.busy     = 1'b0;
        n.idle_out = hold;
      end
    end else begin
      n.pos = s.pos + 16'd1;
      if (req) n.pend = 1'b1;
    end
    return n;
  endfunction

  function automatic logic exp_out(input mstate_t s);
    return s.busy ? ((int'(s.pos) % P) < ON) : s.idle_out;
  endfunction

  mstate_t m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, io.named_input, io.hold);
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("named_output", io.named_output, exp_out(m));
      check("busy", io.busy, m.busy);
    end
  end

  int          busy_cnt = 0;
  int          rises    = 0;
  logic [39:0] pat      = '0;
  logic        busy_q   = 1'b0;
  always @(negedge clk) begin
    if (rst_n && io.busy) begin
      busy_cnt <= busy_cnt + 1;
      pat      <= {pat[38:0], io.named_output};
      if (!busy_q) rises <= rises + 1;
    end
    busy_q <= rst_n && io.busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req_once();
    io.named_input = 1'b1;
    tick(1);
    io.named_input = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (io.busy && k < 200) begin
      tick(1);
      k++;
    end
    check("idle_timeout", io.busy, 1'b0);
    tick(1);
  endtask

  int b0, r0;

  initial begin
    io.named_input = 1'b0;
    io.hold        = 1'b0;
    #22;
    check("reset_out", io.named_output, 1'b0);
    check("reset_busy", io.busy, 1'b0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    tick(2);

    // single request
    b0 = busy_cnt; r0 = rises;
    req_once();
    wait_idle();
    check("single_busy_len", busy_cnt - b0, 20);
    check("single_bursts", rises - r0, 1);
    check("single_pattern", pat[19:0], PAT);

    // request during burst
    b0 = busy_cnt; r0 = rises;
    req_once();
    tick(6);
    req_once();
    wait_idle();
    check("pend_busy_len", busy_cnt - b0, 40);
    check("pend_bursts", rises - r0, 1);
    check("pend_pattern", pat, {PAT, PAT});

    // three requests in one burst give one extra burst
    b0 = busy_cnt; r0 = rises;
    req_once();
    tick(2); req_once();
    tick(3); req_once();
    tick(3); req_once();
    wait_idle();
    check("multi_busy_len", busy_cnt - b0, 40);
    check("multi_bursts", rises - r0, 1);

    // hold in idle and across a burst
    io.hold = 1'b1;
    tick(2);
    check("hold_idle", io.named_output, 1'b1);
    req_once();
    wait_idle();
    check("hold_pattern", pat[19:0], PAT);
    check("hold_after", io.named_output, 1'b1);
    io.hold = 1'b0;
    tick(2);
    check("hold_release", io.named_output, 1'b0);

    // reset mid-burst, asynchronous
    req_once();
    tick(7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", io.named_output, 1'b0);
    check("async_rst_busy", io.busy, 1'b0);
    #10 rst_n = 1'b1;
    b0 = busy_cnt;
    tick(30);
    check("post_rst_idle", busy_cnt - b0, 0);

    // request on the final OFF cycle
    b0 = busy_cnt; r0 = rises;
    req_once();
    tick(18);
    req_once();
    wait_idle();
    check("b2b_busy_len", busy_cnt - b0, 40);
    check("b2b_bursts", rises - r0, 1);
    check("b2b_pattern", pat, {PAT, PAT});

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      io.named_input = ($urandom_range(0, 19) == 0);
      io.hold        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      tick(1);
    end
    io.named_input = 1'b0;
    io.hold        = 1'b0;
    wait_idle();
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/generic_output.md
GENERIC_OUTPUT -- requirements
Module: generic_output

Interface
REQ-001 Parameter ON_CYCLES, default 5: high-phase length of each pulse in clk cycles; SHALL be >= 1.
REQ-002 Parameter OFF_CYCLES, default 5: low-phase length after each pulse in clk cycles; SHALL be >= 1.
REQ-003 Parameter PULSES, default 2: number of on/off pulses per burst; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 named_input  input  1  burst request, sampled on each rising edge; synchronous, already conditioned.
REQ-007 hold  input  1  steady-level request, honoured only when idle.
REQ-008 named_output  output  1  registered drive for the external pin.
REQ-009 busy  output  1  registered; high while a burst is in progress.

Function
REQ-010 FSM states SHALL be IDLE, ON, OFF.
REQ-011 IDLE: named_output SHALL equal hold as sampled at the previous edge; busy SHALL be 0.
REQ-012 IDLE with named_input=1 at edge t: state -> ON, named_output=1 and busy=1 from edge t (1-cycle latency); hold is ignored.
REQ-013 ON SHALL last exactly ON_CYCLES cycles with named_output=1, then go to OFF.
REQ-014 OFF SHALL last exactly OFF_CYCLES cycles with named_output=0.
REQ-015 At the end of OFF: if fewer than PULSES pulses are done -> ON; otherwise, with pending=1 -> ON with a new burst and pending cleared; otherwise -> IDLE.
REQ-016 Burst duration SHALL be PULSES*(ON_CYCLES+OFF_CYCLES) cycles; busy SHALL be high for exactly that span.
REQ-017 named_input=1 while busy SHALL set a one-deep pending flag; further requests while pending=1 are dropped.
REQ-018 named_input=1 on the last OFF cycle SHALL set pending, so a back-to-back burst follows with busy continuously high.
REQ-019 hold changes while busy SHALL have no effect; on return to IDLE, named_output SHALL reflect the current hold one edge later.
REQ-020 The phase counter SHALL be $clog2(max(ON_CYCLES,OFF_CYCLES)+1) bits wide, loaded with phase length minus 1 and counting down to 0, with no wrap-around.
REQ-021 The pulse counter SHALL be $clog2(PULSES+1) bits wide, incremented at the end of each OFF phase and cleared on burst start.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, named_output=0, busy=0, pending=0 and both counters to 0, regardless of clk.
REQ-023 Reset asserted mid-burst SHALL abort the burst; after release, the block SHALL wait in IDLE for a new request.
REQ-024 The first rising edge after rst_n rises SHALL be a normal functional edge.

Structure
REQ-025 State encodings SHALL be localparams in the shared generic_io constants include, reused by generic_input.
REQ-026 The down-counting phase timer SHALL be one sub-module, cycle_timer, with ports load, value, and done.
REQ-027 No other hierarchy; all outputs SHALL be driven directly from flops.

Verification (defaults ON=5, OFF=5, PULSES=2, clk period 10 ns)
REQ-028 Single request: 1-cycle pulse on named_input -> named_output pattern 5H,5L,5H,5L; busy high for 20 cycles; then IDLE.
REQ-029 Request during burst at cycle 7 -> second 20-cycle burst starts immediately after the first; busy high for 40 cycles continuously.
REQ-030 Three requests during one burst -> exactly one extra burst (40 busy cycles total).
REQ-031 Hold: hold=1 in IDLE -> named_output=1 one edge later; trigger with hold=1 -> burst pattern unchanged; after the burst, named_output=1.
REQ-032 Reset mid-burst: rst_n low at cycle 8 -> named_output=0 and busy=0 without a clock edge; no further pulses after release.
REQ-033 Boundary: request on the final OFF cycle -> back-to-back burst with no idle gap and busy never dropping.
